// File: rtl/pp_gen.sv
// pp_gen: two-stage pipelined partial-product generator.
// Takes N-bit operand pairs over a valid/ready handshake and presents a
// registered N-row x W-bit partial-product array whose row sum (mod 2^W)
// is the product. S1 holds the operands, S2 holds the rows.
// Optional feature macro: PP_GEN_SIGNED_EN (adds the is_signed input and
// two's-complement row generation).
`timescale 1ns/1ps

module pp_gen #(
    parameter int N = 16,
    parameter int W = 2 * N
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        a,
    input  logic [N-1:0]        b,
    input  logic [3:0]          in_tag,
`ifdef PP_GEN_SIGNED_EN
    input  logic                is_signed,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0][W-1:0] pp,
    output logic [3:0]          out_tag,
    output logic [15:0]         txn_cnt
);

    // The row width must be exactly twice the operand width.
    if (W != 2 * N) begin : g_width_check
        $error("pp_gen: W must equal 2*N");
    end

    logic                s1_valid_q, s1_valid_d;
    logic [N-1:0]        s1_a_q, s1_a_d;
    logic [N-1:0]        s1_b_q, s1_b_d;
    logic [3:0]          s1_tag_q, s1_tag_d;
`ifdef PP_GEN_SIGNED_EN
    logic                s1_signed_q, s1_signed_d;
    logic [W-1:0]        a_neg;
`endif
    logic                s2_valid_q, s2_valid_d;
    logic [N-1:0][W-1:0] pp_q, pp_d;
    logic [3:0]          s2_tag_q, s2_tag_d;
    logic [15:0]         txn_cnt_q, txn_cnt_d;

    logic                s2_adv;
    logic                s1_adv;
    logic [W-1:0]        a_ext;
    logic [N-1:0][W-1:0] rows;

    // Stage advance: a stage may load when it is empty or the stage after it moves.
    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_ready = rst_n && s1_adv;
    end

    // Build the partial-product rows from the operands held in S1.
    always_comb begin
        a_ext = {{(W-N){1'b0}}, s1_a_q};
`ifdef PP_GEN_SIGNED_EN
        if (s1_signed_q) begin
            a_ext = {{(W-N){s1_a_q[N-1]}}, s1_a_q};
        end
        a_neg = ~a_ext + {{(W-1){1'b0}}, 1'b1};
`endif
        for (int j = 0; j < N; j++) begin
            rows[j] = '0;
            if (s1_b_q[j]) begin
                rows[j] = a_ext << j;
            end
        end
`ifdef PP_GEN_SIGNED_EN
        // The multiplier's sign bit carries weight -2^(N-1), so its row is negated.
        if (s1_signed_q && s1_b_q[N-1]) begin
            rows[N-1] = a_neg << (N-1);
        end
`endif
    end

    // Next-state for both pipeline stages and the transfer counter.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_tag_d    = s1_tag_q;
`ifdef PP_GEN_SIGNED_EN
        s1_signed_d = s1_signed_q;
`endif
        s2_valid_d  = s2_valid_q;
        pp_d        = pp_q;
        s2_tag_d    = s2_tag_q;
        txn_cnt_d   = txn_cnt_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d      = a;
                s1_b_d      = b;
                s1_tag_d    = in_tag;
`ifdef PP_GEN_SIGNED_EN
                s1_signed_d = is_signed;
`endif
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                pp_d     = rows;
                s2_tag_d = s1_tag_q;
            end
        end

        if (s2_valid_q && out_ready) begin
            txn_cnt_d = txn_cnt_q + 16'd1;
        end
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_tag_q    <= '0;
`ifdef PP_GEN_SIGNED_EN
            s1_signed_q <= 1'b0;
`endif
            s2_valid_q  <= 1'b0;
            pp_q        <= '0;
            s2_tag_q    <= '0;
            txn_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_tag_q    <= s1_tag_d;
`ifdef PP_GEN_SIGNED_EN
            s1_signed_q <= s1_signed_d;
`endif
            s2_valid_q  <= s2_valid_d;
            pp_q        <= pp_d;
            s2_tag_q    <= s2_tag_d;
            txn_cnt_q   <= txn_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign pp        = pp_q;
    assign out_tag   = s2_tag_q;
    assign txn_cnt   = txn_cnt_q;

endmodule

// File: tb/tb_pp_gen.sv
// tb_pp_gen: scoreboard bench for pp_gen. Accepted operand pairs push their
// expected product into a queue; a monitor pops on every output transfer and
// checks tag, each row and the row sum against an arithmetic reference.
`timescale 1ns/1ps

module tb_pp_gen;

    localparam int N = 16;
    localparam int W = 32;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  tag;
        logic        sgn;
        logic [31:0] prod;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [N-1:0]        a;
    logic [N-1:0]        b;
    logic [3:0]          in_tag;
    logic                is_signed;
    logic                out_valid;
    logic                out_ready;
    logic [N-1:0][W-1:0] pp;
    logic [3:0]          out_tag;
    logic [15:0]         txn_cnt;

    exp_t                exp_q[$];
    int                  n_cmp  = 0;
    int                  n_fail = 0;
    logic [15:0]         model_cnt = '0;
    logic                hold_valid = 1'b0;
    logic [N-1:0][W-1:0] held_pp;
    logic [3:0]          held_tag;

    pp_gen #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_tag    (in_tag),
`ifdef PP_GEN_SIGNED_EN
        .is_signed (is_signed),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pp        (pp),
        .out_tag   (out_tag),
        .txn_cnt   (txn_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: row j is the (possibly sign-extended) multiplicand times 2^j
    // when multiplier bit j is set; the signed top row carries negative weight.
    function automatic logic [31:0] modelRow(input exp_t e, input int j);
        logic signed [31:0] sa;
        logic [31:0]        ext;
        sa  = $signed(e.a);
        ext = e.sgn ? sa : {16'h0, e.a};
        if (!e.b[j]) return 32'h0;
        if (e.sgn && j == N - 1) return (32'h0 - ext) * (32'h1 << j);
        return ext * (32'h1 << j);
    endfunction

    function automatic logic [31:0] modelProduct(input logic [15:0] x, input logic [15:0] y, input logic sgn);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        sx = $signed(x);
        sy = $signed(y);
        if (sgn) return sx * sy;
        return {16'h0, x} * {16'h0, y};
    endfunction

    // Reset drops every expectation still in flight.
    always @(negedge rst_n) begin
        exp_q.delete();
        model_cnt  = '0;
        hold_valid = 1'b0;
    end

    // Monitor: observe handshakes between edges, check outputs and stall stability.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] sum;
        int          bad_rows;
        if (rst_n) begin
            checkOutput("txn_cnt", 64'(txn_cnt), 64'(model_cnt));
            if (hold_valid) begin
                checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
                checkOutput("stall_pp_stable", 64'(pp === held_pp), 64'd1);
                checkOutput("stall_tag", 64'(out_tag), 64'(held_tag));
            end
            hold_valid = out_valid && !out_ready;
            held_pp    = pp;
            held_tag   = out_tag;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_output: got tag 0x%0h, expected no output", out_tag);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_tag", 64'(out_tag), 64'(e.tag));
                    sum      = '0;
                    bad_rows = 0;
                    for (int j = 0; j < N; j++) begin
                        sum = sum + pp[j];
                        if (pp[j] !== modelRow(e, j)) bad_rows++;
                    end
                    checkOutput("rows_wrong", 64'(bad_rows), 64'd0);
                    checkOutput("row_sum", 64'(sum), 64'(e.prod));
                end
                model_cnt = model_cnt + 16'd1;
            end
            if (in_valid && in_ready) begin
                e.a    = a;
                e.b    = b;
                e.tag  = in_tag;
`ifdef PP_GEN_SIGNED_EN
                e.sgn  = is_signed;
`else
                e.sgn  = 1'b0;
`endif
                e.prod = modelProduct(a, b, e.sgn);
                exp_q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_pp_zero", 64'(pp == '0), 64'd1);
        checkOutput("reset_out_tag", 64'(out_tag), 64'd0);
        checkOutput("reset_txn_cnt", 64'(txn_cnt), 64'd0);
        rst_n = 1'b1;
        step();
    endtask

    // Offer one pair and hold it until accepted (bounded).
    task automatic applyStimulus(input logic [15:0] xa, input logic [15:0] xb,
                                 input logic [3:0] tag, input logic sgn);
        a         = xa;
        b         = xb;
        in_tag    = tag;
        is_signed = sgn;
        in_valid  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                step();
                in_valid = 1'b0;
                return;
            end
            step();
        end
        in_valid = 1'b0;
        checkOutput("accept_timeout", 64'd1, 64'd0);
    endtask

    // Offer a pair into an empty pipeline and check its two-edge latency.
    // Returns at the negedge where the result is presented.
    task automatic latencyProbe(input logic [15:0] xa, input logic [15:0] xb,
                                input logic [3:0] tag, input logic sgn);
        a         = xa;
        b         = xb;
        in_tag    = tag;
        is_signed = sgn;
        in_valid  = 1'b1;
        @(negedge clk);
        checkOutput("lat_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("lat_after_accept_edge", 64'(out_valid), 64'd0);
        step();
        @(negedge clk);
        checkOutput("lat_out_valid", 64'(out_valid), 64'd1);
        checkOutput("lat_out_tag", 64'(out_tag), 64'(tag));
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) return;
        end
        checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [15:0] pa[3];
        logic [15:0] pb[3];
        int          idx;
        logic        fire;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        in_tag    = '0;
        is_signed = 1'b0;
        #2;

        // Reset state, then the small directed product.
        resetDut();
        latencyProbe(16'd3, 16'd5, 4'h2, 1'b0);
        checkOutput("t1_pp0", 64'(pp[0]), 64'h3);
        checkOutput("t1_pp1", 64'(pp[1]), 64'h0);
        checkOutput("t1_pp2", 64'(pp[2]), 64'hC);
        checkOutput("t1_pp15", 64'(pp[15]), 64'h0);
        step();
        @(negedge clk);
        checkOutput("t1_txn_cnt", 64'(txn_cnt), 64'd1);
        step();

        // All-ones operands.
        latencyProbe(16'hFFFF, 16'hFFFF, 4'h7, 1'b0);
        checkOutput("ones_pp0", 64'(pp[0]), 64'hFFFF);
        checkOutput("ones_pp15", 64'(pp[15]), 64'h7FFF8000);
        step();
        waitDrain();
        step();

        // Back-to-back random pairs with the sink always ready.
        resetDut();
        for (int i = 0; i < 20; i++) begin
            a        = 16'($urandom);
            b        = 16'($urandom);
            in_tag   = 4'($urandom);
            in_valid = 1'b1;
            @(negedge clk);
            checkOutput("b2b_in_ready", 64'(in_ready), 64'd1);
            step();
        end
        in_valid = 1'b0;
        waitDrain();
        checkOutput("b2b_txn_cnt", 64'(txn_cnt), 64'd20);
        step();

        // Stall: three pairs offered while the sink refuses for five cycles.
        pa[0] = 16'h1234; pb[0] = 16'h00F1;
        pa[1] = 16'h8001; pb[1] = 16'hA5A5;
        pa[2] = 16'h0F0F; pb[2] = 16'h7003;
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 3);
            if (idx < 3) begin
                a      = pa[idx];
                b      = pb[idx];
                in_tag = 4'(idx + 9);
            end
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            step();
        end
        checkOutput("stall_accepted", 64'(idx), 64'd2);
        @(negedge clk);
        checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
        step();
        out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 3; c++) begin
            in_valid = 1'b1;
            a        = pa[idx];
            b        = pb[idx];
            in_tag   = 4'(idx + 9);
            @(negedge clk);
            if (in_ready) idx++;
            step();
        end
        in_valid = 1'b0;
        checkOutput("stall_all_accepted", 64'(idx), 64'd3);
        waitDrain();
        step();

        // Asynchronous reset with two pairs in flight.
        out_ready = 1'b0;
        applyStimulus(16'h00AA, 16'h0055, 4'h3, 1'b0);
        applyStimulus(16'h0BBB, 16'h0CCC, 4'h4, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("async_rst_pp_zero", 64'(pp == '0), 64'd1);
        checkOutput("async_rst_txn_cnt", 64'(txn_cnt), 64'd0);
        checkOutput("async_rst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        latencyProbe(16'h0042, 16'h0101, 4'hE, 1'b0);
        step();
        waitDrain();
        step();

        // Random traffic with random back-pressure.
        for (int c = 0; c < 300; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 2) != 0) begin
                in_valid = 1'b1;
                a        = 16'($urandom);
                b        = 16'($urandom);
                in_tag   = 4'($urandom);
`ifdef PP_GEN_SIGNED_EN
                is_signed = 1'($urandom);
`endif
            end
            @(negedge clk);
            fire = in_valid && in_ready;
            step();
            if (fire) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waitDrain();
        step();

`ifdef PP_GEN_SIGNED_EN
        // Signed: (-3) * (-2) = 6.
        latencyProbe(16'hFFFD, 16'hFFFE, 4'h5, 1'b1);
        checkOutput("signed_pp0", 64'(pp[0]), 64'h0);
        checkOutput("signed_pp1", 64'(pp[1]), 64'hFFFFFFFA);
        checkOutput("signed_pp14", 64'(pp[14]), 64'(32'hFFFFFFFD << 14));
        checkOutput("signed_pp15", 64'(pp[15]), 64'h00018000);
        step();
        waitDrain();
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
